// File: rtl/mixer_sample_sequencer.sv
// rtl/mixer_sample_sequencer.sv - sample-rate sequencer for the 4-channel mixer
// Snapshots channel levels on a divider tick, accumulates one channel per clock, emits a saturated sample.
module mixer_sample_sequencer #(
  parameter int SAMPLE_DIV = 256,
  parameter int IN_SHIFT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  input  logic [3:0] mute,
  input  logic       vol_wr_en,
  input  logic [1:0] vol_wr_ch,
  input  logic [1:0] vol_wr_data,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic       clip,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [1:0]  VOL_FULL = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] div_cnt;
  logic        tick;
  logic        snap;
  logic        acc_step;
  logic        finish;

  logic [3:0]  in_arr  [4];
  logic [1:0]  vol_reg [4];
  logic [3:0]  sh_in   [4];
  logic [1:0]  sh_vol  [4];
  logic [3:0]  sh_mute;
  logic [9:0]  acc;
  logic [1:0]  idx;

  logic [7:0]  ch_val;
  logic [7:0]  scaled;

  assign in_arr[0] = in1;
  assign in_arr[1] = in2;
  assign in_arr[2] = in3;
  assign in_arr[3] = in4;

  // Gray-ordered volume codes: 00=1/4, 01=1/2, 11=3/4, 10=full.
  function automatic logic [7:0] vol_scale(input logic [7:0] v, input logic [1:0] code);
    logic [7:0] r;
    case (code)
      2'b00:   r = v >> 2;
      2'b01:   r = v >> 1;
      2'b11:   r = (v >> 1) + (v >> 2);
      default: r = v;
    endcase
    return r;
  endfunction

  // Free-running sample-rate divider; independent of the sequencer state.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        vol_reg[i] <= VOL_FULL;
      end
    end else if (vol_wr_en) begin
      vol_reg[vol_wr_ch] <= vol_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A tick seen outside IDLE is dropped rather than restarting the sample.
  always_comb begin
    state_nxt = state;
    snap      = 1'b0;
    acc_step  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          snap      = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        acc_step = 1'b1;
        if (idx == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ch_val = {4'b0000, sh_in[idx]} << IN_SHIFT;
  assign scaled = sh_mute[idx] ? 8'd0 : vol_scale(ch_val, sh_vol[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sh_in[i]  <= '0;
        sh_vol[i] <= VOL_FULL;
      end
      sh_mute <= '0;
      acc     <= '0;
      idx     <= '0;
    end else if (snap) begin
      for (int i = 0; i < 4; i++) begin
        sh_in[i]  <= in_arr[i];
        sh_vol[i] <= vol_reg[i];
      end
      sh_mute <= mute;
      acc     <= '0;
      idx     <= '0;
    end else if (acc_step) begin
      acc <= acc + {2'b00, scaled};
      idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      clip         <= 1'b0;
    end else begin
      sample_valid <= finish;
      clip         <= finish && (acc > 10'd255);
      if (finish) begin
        sample_out <= (acc > 10'd255) ? 8'hFF : acc[7:0];
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
